// File: rtl/adder_mul_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package adder_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/full_adder_n.sv
// N-bit ripple-carry adder shared by the multiplier datapath.
module full_adder_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         ci_i,
    output logic [N-1:0] sum_o,
    output logic         co_o
);

    logic [N:0] carry;

    assign carry[0] = ci_i;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign co_o = carry[N];

endmodule

// File: rtl/adder_mul_seq.sv
// Unsigned NxN shift-and-add multiplier: one shared adder, one partial product per cycle.
//  state | meaning
//  IDLE  | waiting for start, ready=1
//  RUN   | accumulating one multiplier bit per cycle, busy=1
//  DONE  | product in p, done=1 for one cycle, start accepted back-to-back
module adder_mul_seq
    import adder_mul_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int             CW       = cnt_w(N);
    localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);

    mul_state_t     state_q;
    logic [N-1:0]   mcand_q;
    logic [N-1:0]   acc_hi_q;
    logic [N-1:0]   acc_lo_q;
    logic [CW-1:0]  cnt_q;
    logic [2*N-1:0] p_q;
    logic           ready_q;
    logic           busy_q;
    logic           done_q;

    logic [N-1:0]   addend;
    logic [N-1:0]   sum;
    logic           co;
    logic [2*N-1:0] shift_d;

    assign addend = mcand_q & {N{acc_lo_q[0]}};

    full_adder_n #(.N(N)) u_adder (
        .a_i   (acc_hi_q),
        .b_i   (addend),
        .ci_i  (1'b0),
        .sum_o (sum),
        .co_o  (co)
    );

    // The carry-out lands in acc_hi[N-1], so no product bit is ever dropped.
    assign shift_d = {co, sum, acc_lo_q[N-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q  <= a;
                        acc_lo_q <= b;
                        acc_hi_q <= '0;
                        cnt_q    <= '0;
                        state_q  <= RUN;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    {acc_hi_q, acc_lo_q} <= shift_d;
                    cnt_q                <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        p_q     <= shift_d;
                        state_q <= DONE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q  <= a;
                        acc_lo_q <= b;
                        acc_hi_q <= '0;
                        cnt_q    <= '0;
                        state_q  <= RUN;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign p     = p_q;

endmodule

// File: tb/tb_adder_mul_seq.sv
// Scoreboard bench for adder_mul_seq at N=4 and N=8.
module tb_adder_mul_seq;

    typedef struct {
        logic [63:0] p;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst4, rst8;
    logic       start4, start8;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       ready4, busy4, done4;
    logic       ready8, busy8, done8;
    logic [7:0]  p4;
    logic [15:0] p8;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q4[$];
    exp_t q8[$];
    exp_t e4, e8;

    adder_mul_seq #(.N(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
        .ready(ready4), .busy(busy4), .done(done4), .p(p4)
    );

    adder_mul_seq #(.N(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
        .ready(ready8), .busy(busy8), .done(done8), .p(p8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst4 === 1'b0 && done4 === 1'b1) begin
            if (q4.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL n4_unexpected_done: got done with p=%0d at cycle %0d, expected none", p4, cyc);
            end else begin
                e4 = q4.pop_front();
                chk("n4_product", 64'(p4), e4.p);
                chk("n4_done_cycle", 64'(cyc), 64'(e4.cyc));
            end
        end
        if (rst8 === 1'b0 && done8 === 1'b1) begin
            if (q8.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL n8_unexpected_done: got done with p=%0d at cycle %0d, expected none", p8, cyc);
            end else begin
                e8 = q8.pop_front();
                chk("n8_product", 64'(p8), e8.p);
                chk("n8_done_cycle", 64'(cyc), 64'(e8.cyc));
            end
        end
    end

    // Present a start for one cycle once ready; expected product and done cycle go to the scoreboard.
    task automatic go(input bit big, input int av, input int bv, input logic [63:0] prod, input bit push);
        int   n;
        exp_t e;
        n = big ? 8 : 4;
        for (int i = 0; i < 100; i++) begin
            if ((big ? ready8 : ready4) === 1'b1) break;
            tick();
        end
        if ((big ? ready8 : ready4) !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: got ready=0 after 100 cycles, expected 1");
        end
        if (big) begin
            a8 = 8'(av); b8 = 8'(bv); start8 = 1'b1;
        end else begin
            a4 = 4'(av); b4 = 4'(bv); start4 = 1'b1;
        end
        e.p   = prod;
        e.cyc = cyc + 1 + n;
        if (push) begin
            if (big) q8.push_back(e);
            else     q4.push_back(e);
        end
        tick();
        start4 = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic drain(input bit big);
        for (int i = 0; i < 200; i++) begin
            if ((big ? q8.size() : q4.size()) == 0) break;
            tick();
        end
        if ((big ? q8.size() : q4.size()) != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done within 200 cycles, expected one");
            q4.delete();
            q8.delete();
        end
        tick();
    endtask

    initial begin
        rst4 = 1'b1; rst8 = 1'b1;
        start4 = 1'b0; start8 = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        tick();
        tick();
        chk("rst_ready4", 64'(ready4), 64'd1);
        chk("rst_busy4",  64'(busy4),  64'd0);
        chk("rst_done4",  64'(done4),  64'd0);
        chk("rst_p4",     64'(p4),     64'd0);
        chk("rst_ready8", 64'(ready8), 64'd1);
        chk("rst_p8",     64'(p8),     64'd0);
        rst4 = 1'b0; rst8 = 1'b0;
        tick();

        // 3 x 5: busy for exactly four cycles, then done, then p holds
        go(1'b0, 3, 5, 64'd15, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("run_busy",  64'(busy4),  64'd1);
            chk("run_ready", 64'(ready4), 64'd0);
            tick();
        end
        chk("done_ready", 64'(ready4), 64'd1);
        chk("done_busy",  64'(busy4),  64'd0);
        drain(1'b0);
        chk("hold_p15",    64'(p4),    64'd15);
        chk("idle_done",   64'(done4), 64'd0);
        chk("idle_ready",  64'(ready4), 64'd1);

        // carry-out path
        go(1'b0, 15, 15, 64'd225, 1'b1);
        drain(1'b0);

        // zero operands
        go(1'b0, 0, 9, 64'd0, 1'b1);
        drain(1'b0);
        go(1'b0, 7, 0, 64'd0, 1'b1);
        drain(1'b0);

        // start and operand changes during RUN are ignored
        go(1'b0, 6, 7, 64'd42, 1'b1);
        a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        drain(1'b0);
        tick();
        chk("ign_p42",   64'(p4),     64'd42);
        chk("ign_ready", 64'(ready4), 64'd1);
        chk("ign_busy",  64'(busy4),  64'd0);

        // back-to-back with start held through DONE
        begin
            exp_t e;
            a4 = 4'd2; b4 = 4'd3; start4 = 1'b1;
            e.p = 64'd6; e.cyc = cyc + 5;
            q4.push_back(e);
            tick();
            for (int i = 0; i < 4; i++) begin
                chk("b2b_ready_run", 64'(ready4), 64'd0);
                tick();
            end
            chk("b2b_ready_done", 64'(ready4), 64'd1);
            a4 = 4'd5; b4 = 4'd5;
            e.p = 64'd25; e.cyc = cyc + 5;
            q4.push_back(e);
            tick();
            start4 = 1'b0;
            chk("b2b_busy_again", 64'(busy4), 64'd1);
            drain(1'b0);
            chk("b2b_p25", 64'(p4), 64'd25);
        end

        // N=8 full-scale operands
        go(1'b1, 255, 255, 64'd65025, 1'b1);
        drain(1'b1);
        chk("n8_hold", 64'(p8), 64'd65025);

        // reset during RUN cycle 4 discards the operation
        go(1'b1, 200, 100, 64'd0, 1'b0);
        tick();
        tick();
        tick();
        chk("pre_rst_busy8", 64'(busy8), 64'd1);
        rst8 = 1'b1;
        #1;
        chk("mid_rst_p8",     64'(p8),     64'd0);
        chk("mid_rst_ready8", 64'(ready8), 64'd1);
        chk("mid_rst_busy8",  64'(busy8),  64'd0);
        chk("mid_rst_done8",  64'(done8),  64'd0);
        tick();
        rst8 = 1'b0;
        tick();
        go(1'b1, 10, 20, 64'd200, 1'b1);
        drain(1'b1);
        tick();
        chk("final_q_empty", 64'(q4.size() + q8.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
